// File: rtl/loop_stack_param_if.sv
// Bundles the loop-stack push/pop controls, skip-mode controls and status
// outputs so the stack can be dropped in behind a single port.
interface loop_stack_param_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 16,
  parameter int NEST_WIDTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] address_in;
  logic [ADDR_WIDTH-1:0] address_out;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;
  logic                  skip_start;
  logic                  open_bracket;
  logic                  close_bracket;
  logic                  skipping;
  logic                  skip_done;
  logic [NEST_WIDTH-1:0] nest;

  modport master (
    output push, pop, address_in, skip_start, open_bracket, close_bracket,
    input  address_out, count, empty, full, overflow, underflow,
           skipping, skip_done, nest
  );

  modport slave (
    input  push, pop, address_in, skip_start, open_bracket, close_bracket,
    output address_out, count, empty, full, overflow, underflow,
           skipping, skip_done, nest
  );
endinterface

// File: rtl/loop_stack_param.sv
// LIFO of loop-start addresses with sticky over/underflow flags, plus a
// bracket-matching skip mode that freezes the stack while active.
module loop_stack_param #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 16,
  parameter int NEST_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  loop_stack_param_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
  localparam logic [NEST_WIDTH-1:0] NEST_MAX = '1;

  typedef enum logic {
    S_IDLE,
    S_SKIP
  } state_e;

  state_e                state_q, state_d;
  logic [NEST_WIDTH-1:0] nest_q, nest_d;
  logic                  skip_done_q, skip_done_d;
  logic                  nest_ovf;

  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_en;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         top_idx;
  logic                  empty;
  logic                  full;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign top_idx = AW'(count_q - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      nest_q      <= '0;
      skip_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nest_q      <= nest_d;
      skip_done_q <= skip_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    nest_d      = nest_q;
    skip_done_d = 1'b0;
    nest_ovf    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.skip_start) begin
          state_d = S_SKIP;
          nest_d  = '0;
        end
      end
      S_SKIP: begin
        if (bus.open_bracket && !bus.close_bracket) begin
          if (nest_q == NEST_MAX) nest_ovf = 1'b1;
          else                    nest_d   = nest_q + 1'b1;
        end else if (bus.close_bracket && !bus.open_bracket) begin
          if (nest_q != '0) begin
            nest_d = nest_q - 1'b1;
          end else begin
            state_d     = S_IDLE;
            skip_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Simultaneous push+pop on a non-empty stack overwrites the top in place.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q | nest_ovf;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = AW'(count_q);
    if (state_q == S_IDLE) begin
      if (bus.push && bus.pop) begin
        wr_en = 1'b1;
        if (empty) count_d = count_q + 1'b1;
        else       wr_idx  = top_idx;
      end else if (bus.push) begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
        end
      end else if (bus.pop) begin
        if (empty) unf_d   = 1'b1;
        else       count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_idx] <= bus.address_in;
  end

  assign bus.address_out = empty ? '0 : mem_q[top_idx];
  assign bus.count       = count_q;
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
  assign bus.skipping    = (state_q == S_SKIP);
  assign bus.skip_done   = skip_done_q;
  assign bus.nest        = nest_q;

endmodule

// File: doc/loop_stack_param.md
LOOP_STACK_PARAM -- requirements
Module: loop_stack_param

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, width of stored loop addresses.
REQ-002 The block SHALL have parameter DEPTH, default 16, stack entries (legal range 2..1024).
REQ-003 The block SHALL have parameter NEST_WIDTH, default 8, width of the skip-mode nesting counter.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port push  input  1  push address_in onto stack.
REQ-007 The block SHALL have port pop  input  1  discard top entry.
REQ-008 The block SHALL have port address_in  input  ADDR_WIDTH  address pushed (loop-start PC).
REQ-009 The block SHALL have port address_out  output  ADDR_WIDTH  current top-of-stack address.
REQ-010 The block SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-011 The block SHALL have ports empty, full  output  1 each  count==0, count==DEPTH.
REQ-012 The block SHALL have ports overflow, underflow  output  1 each  sticky error flags.
REQ-013 The block SHALL have ports skip_start, open_bracket, close_bracket  input  1 each  skip-mode controls.
REQ-014 The block SHALL have ports skipping  output  1  skip mode active; skip_done  output  1  one-cycle pulse at end of skip.
REQ-015 The block SHALL have port nest  output  NEST_WIDTH  current skip nesting depth.

Function
REQ-016 Stack SHALL be LIFO of DEPTH entries x ADDR_WIDTH, pointer sp = count.
REQ-017 address_out SHALL be combinational from registers: entry[count-1] when !empty, else all zeros; new top visible the cycle after the edge that changed it.
REQ-018 push & !pop & !full SHALL write address_in to entry[count] and increment count.
REQ-019 pop & !push & !empty SHALL decrement count; stored data below top unchanged.
REQ-020 push & pop with !empty SHALL replace top entry with address_in, count unchanged.
REQ-021 push & pop with empty SHALL act as plain push.
REQ-022 push when full (without pop) SHALL be ignored and set overflow; pop when empty (without push) SHALL be ignored and set underflow.
REQ-023 overflow and underflow SHALL stay set until rst.
REQ-024 Skip FSM SHALL have states IDLE and SKIP; skipping = (state==SKIP).
REQ-025 In IDLE, skip_start SHALL move to SKIP with nest=0; open/close_bracket ignored in IDLE.
REQ-026 In SKIP: open_bracket alone SHALL increment nest; close_bracket alone with nest>0 SHALL decrement nest; close_bracket alone with nest==0 SHALL return to IDLE and assert skip_done for exactly that following cycle.
REQ-027 In SKIP, open_bracket & close_bracket together SHALL leave nest and state unchanged; skip_start SHALL be ignored.
REQ-028 open_bracket at nest == 2^NEST_WIDTH-1 SHALL saturate nest and set overflow.
REQ-029 While skipping, push and pop SHALL be ignored with no stack change and no error flag.
REQ-030 skip_done SHALL be 0 in every cycle except the one after the terminating close_bracket.

Reset
REQ-031 rst SHALL take priority over all inputs in the same cycle.
REQ-032 After rst: count=0, empty=1, full=0, address_out=0, overflow=0, underflow=0, state=IDLE, skipping=0, nest=0, skip_done=0.
REQ-033 rst mid-skip SHALL abort skip with no skip_done pulse; storage contents need not be cleared.

Verification
REQ-034 rst; push 0x12C; push 0x06E -> count=2, address_out=0x06E; pop -> count=1, address_out=0x12C; pop -> empty=1, address_out=0x000.
REQ-035 DEPTH=16: push 0x000..0x00F -> full=1; push 0x3FF -> ignored, overflow=1, address_out=0x00F; rst -> overflow=0.
REQ-036 rst; pop -> underflow=1, count=0; push 0x055 & pop same cycle -> count=1, address_out=0x055; push 0x0AA & pop -> count=1, address_out=0x0AA.
REQ-037 skip_start; open, open, close, close, close -> nest 1,2,1,0, then IDLE with skip_done high for one cycle; push during SKIP ignored.
REQ-038 skip_start; open & close together -> nest=0, still skipping; open; rst -> skipping=0, nest=0, skip_done never asserted.
